// File: rtl/cpu_ctrl_fsm_if.sv
// Host program/data load port of cpu_ctrl_fsm: valid/ready write handshake.
// The host drives the master modport; the controller takes the slave modport.
interface cpu_ctrl_fsm_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (output load_valid, output load_addr, output load_data, input load_ready);
    modport slave  (input load_valid, input load_addr, input load_data, output load_ready);
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Synchronous fetch/decode/operand/execute/write-back sequencer for ram8, PC and ALU.
// Define CPU_CTRL_SINGLE_STEP_EN to add the i_step input and a PAUSE state after each write-back.
module cpu_ctrl_fsm #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int IR_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic              i_step,
`endif
    cpu_ctrl_fsm_if.slave     host,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_rdata,
    input  logic [ADDR_W-1:0] i_pc_val,
    output logic              o_pc_inc,
    output logic              o_pc_rst,
    output logic [DATA_W-1:0] o_alu_x,
    output logic [DATA_W-1:0] o_alu_y,
    output logic              o_alu_sel,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ALU  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_OPA    = 4'd3,
        ST_OPB    = 4'd4,
        ST_EXEC   = 4'd5,
        ST_WB     = 4'd6,
        ST_HALTED = 4'd7
`ifdef CPU_CTRL_SINGLE_STEP_EN
        , ST_PAUSE = 4'd8
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    // Only the instruction fields the sequencer consumes are held.
    logic              r_ir_sel;
    logic [2:0]        r_ir_dst;
    logic [2:0]        r_ir_src_a;
    logic [2:0]        r_ir_src_b;
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_done;
    logic              r_err;

    logic [2:0]        w_opcode;
    logic              w_ir_load;
    logic              w_set_done;
    logic              w_set_err;
    logic              w_clr_status;

    assign w_opcode = i_ram_rdata[IR_W-1 -: 3];

    always_comb begin
        w_state_next    = r_state;
        o_ram_addr      = '0;
        o_ram_wdata     = '0;
        o_ram_we        = 1'b0;
        o_pc_inc        = 1'b0;
        o_pc_rst        = 1'b0;
        host.load_ready = 1'b0;
        o_busy          = 1'b1;
        w_ir_load       = 1'b0;
        w_set_done      = 1'b0;
        w_set_err       = 1'b0;
        w_clr_status    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                o_busy          = 1'b0;
                host.load_ready = 1'b1;
                if (host.load_valid) begin
                    o_ram_we    = 1'b1;
                    o_ram_addr  = host.load_addr;
                    o_ram_wdata = host.load_data;
                end else if (i_start) begin
                    o_pc_rst     = 1'b1;
                    w_clr_status = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_ram_addr   = i_pc_val;
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_ir_load = 1'b1;
                case (w_opcode)
                    OP_ALU:  w_state_next = ST_OPA;
                    OP_NOP: begin
                        o_pc_inc     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    OP_HALT: begin
                        w_set_done   = 1'b1;
                        w_state_next = ST_HALTED;
                    end
                    default: begin
                        w_set_done   = 1'b1;
                        w_set_err    = 1'b1;
                        w_state_next = ST_HALTED;
                    end
                endcase
            end
            ST_OPA: begin
                o_ram_addr   = r_ir_src_a;
                w_state_next = ST_OPB;
            end
            ST_OPB: begin
                o_ram_addr   = r_ir_src_b;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: w_state_next = ST_WB;
            ST_WB: begin
                o_ram_we     = 1'b1;
                o_ram_addr   = r_ir_dst;
                o_ram_wdata  = i_alu_result;
                o_pc_inc     = 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
                w_state_next = ST_PAUSE;
`else
                w_state_next = ST_FETCH;
`endif
            end
`ifdef CPU_CTRL_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (i_step) begin
                    w_state_next = ST_FETCH;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
        // A reset cycle must not disturb RAM contents or the PC.
        if (!i_reset) begin
            o_ram_we     = 1'b0;
            o_pc_inc     = 1'b0;
            o_pc_rst     = 1'b0;
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_ir_sel       <= 1'b0;
            r_ir_dst       <= '0;
            r_ir_src_a     <= '0;
            r_ir_src_b     <= '0;
            r_alu_x        <= '0;
            r_alu_y        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_result_valid <= (r_state == ST_WB);
            if (w_ir_load) begin
                r_ir_sel   <= i_ram_rdata[12];
                r_ir_dst   <= i_ram_rdata[10:8];
                r_ir_src_a <= i_ram_rdata[6:4];
                r_ir_src_b <= i_ram_rdata[2:0];
            end
            if (r_state == ST_OPB) begin
                r_alu_x <= i_ram_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_alu_y <= i_ram_rdata;
            end
            if (r_state == ST_WB) begin
                r_result <= i_alu_result;
            end
            if (w_clr_status) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_alu_x        = r_alu_x;
    assign o_alu_y        = r_alu_y;
    assign o_alu_sel      = r_ir_sel;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with behavioural ram8 (registered read), PC and add/sub ALU.
module tb_cpu_ctrl_fsm;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              step;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              pc_rst;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] mem [0:7];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_ctrl_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

    cpu_ctrl_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IR_W(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .i_step         (step),
`endif
        .host           (host_if.slave),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .o_ram_we       (ram_we),
        .i_ram_rdata    (ram_rdata),
        .i_pc_val       (pc),
        .o_pc_inc       (pc_inc),
        .o_pc_rst       (pc_rst),
        .o_alu_x        (alu_x),
        .o_alu_y        (alu_y),
        .o_alu_sel      (alu_sel),
        .i_alu_result   (alu_result),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (pc_rst)      pc <= '0;
        else if (pc_inc) pc <= pc + 3'd1;
    end

    assign alu_result = alu_sel ? (alu_x - alu_y) : (alu_x + alu_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        host_if.load_valid = 1'b1;
        host_if.load_addr  = a;
        host_if.load_data  = d;
        start              = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        host_if.load_valid = 1'b0;
        start              = 1'b1;
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        do begin
            nxt();
            cyc++;
        end while (!done && cyc < max);
    endtask

    int we_cnt, inc_cnt, rv_cnt, cyc;

    initial begin
        reset = 1'b0; start = 1'b0; step = 1'b1;
        host_if.load_valid = 1'b0; host_if.load_addr = '0; host_if.load_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_load_ready", {31'd0, host_if.load_ready}, 32'd1);
        reset = 1'b1;

        // add program: mem3 = mem4 + mem5
        load(0, 32'h2345); load(1, 32'hE000); load(2, 32'h0); load(3, 32'hAA);
        load(4, 32'd5);    load(5, 32'd7);    load(6, 32'h0); load(7, 32'h0);
        start_run();
        chk("add_pc_rst", {31'd0, pc_rst}, 32'd1);
        we_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            nxt();
            if (k < 6 && ram_we) we_cnt++;
            if (k == 6) begin
                chk("add_wb_we", {31'd0, ram_we}, 32'd1);
                chk("add_wb_addr", {29'd0, ram_addr}, 32'd3);
                chk("add_wb_data", ram_wdata, 32'd12);
                chk("add_alu_x", alu_x, 32'd5);
                chk("add_alu_y", alu_y, 32'd7);
                chk("add_wb_pc_inc", {31'd0, pc_inc}, 32'd1);
            end
            if (k == 7) begin
                chk("add_result", result, 32'd12);
                chk("add_result_valid", {31'd0, result_valid}, 32'd1);
                chk("add_pc_after_wb", {29'd0, pc}, 32'd1);
            end
            if (k == 8) begin
                chk("add_rv_pulse_end", {31'd0, result_valid}, 32'd0);
                chk("add_done_early", {31'd0, done}, 32'd0);
            end
            if (k == 9) begin
                chk("add_done", {31'd0, done}, 32'd1);
                chk("add_err", {31'd0, err}, 32'd0);
                chk("add_busy_end", {31'd0, busy}, 32'd0);
            end
        end
        chk("add_no_early_we", we_cnt, 32'd0);
        chk("add_mem3", mem[3], 32'd12);

        // NOP then HALT
        load(0, 32'h0000);
        start_run();
        we_cnt = 0; inc_cnt = 0; cyc = 0;
        do begin
            nxt();
            cyc++;
            if (pc_inc) inc_cnt++;
            if (ram_we) we_cnt++;
        end while (!done && cyc < 20);
        chk("nop_cycles", cyc, 32'd5);
        chk("nop_pc_inc_cnt", inc_cnt, 32'd1);
        chk("nop_we_cnt", we_cnt, 32'd0);
        chk("nop_err", {31'd0, err}, 32'd0);

        // illegal opcode
        load(0, 32'h4000);
        start_run();
        we_cnt = 0; cyc = 0;
        do begin
            nxt();
            cyc++;
            if (ram_we) we_cnt++;
        end while (!done && cyc < 20);
        chk("ill_cycles", cyc, 32'd3);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_we_cnt", we_cnt, 32'd0);
        start_run();
        nxt();
        chk("ill_restart_done", {31'd0, done}, 32'd0);
        chk("ill_restart_err", {31'd0, err}, 32'd0);
        chk("ill_restart_busy", {31'd0, busy}, 32'd1);
        wait_done(20, cyc);
        chk("ill_rehalt_err", {31'd0, err}, 32'd1);

        // reset in OPB of the add program
        load(0, 32'h2345); load(3, 32'hAA);
        start_run();
        rv_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            nxt();
            if (result_valid) rv_cnt++;
        end
        chk("rst_opb_addr", {29'd0, ram_addr}, 32'd5);
        reset = 1'b0;
        #1;
        chk("rst_opb_we", {31'd0, ram_we}, 32'd0);
        chk("rst_opb_pc_inc", {31'd0, pc_inc}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_opb_idle_busy", {31'd0, busy}, 32'd0);
        chk("rst_opb_result", result, 32'd0);
        for (int k = 0; k < 8; k++) begin
            nxt();
            if (result_valid) rv_cnt++;
        end
        chk("rst_opb_rv_cnt", rv_cnt, 32'd0);
        chk("rst_opb_mem3", mem[3], 32'hAA);

        // load and start together: load wins
        @(negedge clk);
        host_if.load_valid = 1'b1; host_if.load_addr = 3'd6; host_if.load_data = 32'h1234; start = 1'b1;
        #1;
        chk("both_ram_we", {31'd0, ram_we}, 32'd1);
        chk("both_ram_addr", {29'd0, ram_addr}, 32'd6);
        chk("both_pc_rst", {31'd0, pc_rst}, 32'd0);
        @(negedge clk);
        host_if.load_valid = 1'b0; start = 1'b0;
        #1;
        chk("both_busy", {31'd0, busy}, 32'd0);
        chk("both_mem6", mem[6], 32'h1234);
        start_run();
        chk("solo_pc_rst", {31'd0, pc_rst}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        host_if.load_valid = 1'b1; host_if.load_addr = 3'd7; host_if.load_data = 32'h55;
        #1;
        chk("solo_busy", {31'd0, busy}, 32'd1);
        chk("busy_load_ready", {31'd0, host_if.load_ready}, 32'd0);
        chk("busy_load_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        host_if.load_valid = 1'b0;
        wait_done(30, cyc);
        chk("solo_done", {31'd0, done}, 32'd1);
        chk("solo_result", result, 32'd12);
        chk("busy_load_mem7", mem[7], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
